// File: rtl/adpll_cfg_pkg.sv
// adpll_cfg_pkg: shared FSM encoding and default sizing for the ADPLL configuration bank
package adpll_cfg_pkg;
  typedef enum logic {IDLE, PEND} state_t;
  localparam int NPARAM_DEF = 8;
  localparam int PW_DEF = 5;
  localparam int SELW_DEF = 3;
  localparam int NOBS_DEF = 4;
  localparam int OBSW_DEF = 2;
  localparam int OW_DEF = 8;
  localparam int SYNC_DEF = 2;
endpackage

// File: rtl/adpll_sync_edge.sv
// adpll_sync_edge: synchronises an async pin strobe and emits a one-cycle rising-edge pulse
module adpll_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);
  logic [STAGES:0] chain;
  always_ff @(posedge clk)
    chain <= rst ? '0 : {chain[STAGES-1:0], din};
  assign pulse = chain[STAGES-1] & ~chain[STAGES];
endmodule

// File: rtl/adpll_cfg_bank.sv
// adpll_cfg_bank: shadow/active ADPLL parameter bank with sign-magnitude observation port
// Optional parameter readback on dout is built only when CFG_READBACK_EN is defined.
module adpll_cfg_bank
  import adpll_cfg_pkg::*;
#(
  parameter int NPARAM = NPARAM_DEF,
  parameter int PW = PW_DEF,
  parameter int SELW = SELW_DEF,
  parameter int NOBS = NOBS_DEF,
  parameter int OBSW = OBSW_DEF,
  parameter int OW = OW_DEF,
  parameter int SYNC_STAGES = SYNC_DEF,
  parameter logic [NPARAM*PW-1:0] DEFAULT_FLAT = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pgm,
  input  logic                 clr,
  input  logic [SELW-1:0]      param_sel,
  input  logic [PW-1:0]        pgm_value,
  input  logic                 upd_tick,
  input  logic [OBSW-1:0]      obs_sel,
  input  logic                 rb_mode,
  input  logic [NOBS*OW-1:0]   obs_data,
  output logic [NPARAM*PW-1:0] param_flat,
  output logic                 cfg_update,
  output logic                 pending,
  output logic                 sel_err,
  output logic [PW-1:0]        dout,
  output logic                 sign
);
  localparam int MAXV = 2**PW - 1;
  logic pgm_p, clr_p, wr_ok, commit, neg, sat;
  logic [NPARAM-1:0][PW-1:0] shadow, active, shadow_nxt;
  state_t state, state_nxt;
  logic [OW-1:0] x;
  logic [OW:0] ext, mag_full;
  logic [PW-1:0] mag, dout_d;
  logic sign_d;
  adpll_sync_edge #(.STAGES(SYNC_STAGES)) u_pgm (.clk(clk), .rst(rst), .din(pgm), .pulse(pgm_p));
  adpll_sync_edge #(.STAGES(SYNC_STAGES)) u_clr (.clk(clk), .rst(rst), .din(clr), .pulse(clr_p));
  // a write landing in the tick cycle is folded into that same commit
  always_comb begin
    wr_ok = pgm_p && int'(param_sel) < NPARAM;
    shadow_nxt = shadow;
    if (wr_ok) shadow_nxt[param_sel] = pgm_value;
    commit = upd_tick && (state == PEND || wr_ok);
    state_nxt = commit ? IDLE : (wr_ok ? PEND : state);
  end
  always_ff @(posedge clk) begin
    if (rst || clr_p) begin
      shadow <= DEFAULT_FLAT;
      active <= DEFAULT_FLAT;
      state <= IDLE;
      pending <= 1'b0;
      sel_err <= 1'b0;
      cfg_update <= clr_p & ~rst;
    end else begin
      shadow <= shadow_nxt;
      if (commit) active <= shadow_nxt;
      state <= state_nxt;
      pending <= state_nxt == PEND;
      sel_err <= sel_err | (pgm_p & ~wr_ok);
      cfg_update <= commit;
    end
  end
  assign param_flat = active;
  always_comb begin
    x = int'(obs_sel) < NOBS ? obs_data[int'(obs_sel)*OW +: OW] : '0;
    neg = x[OW-1];
    ext = {x[OW-1], x};
    mag_full = neg ? ~ext + 1'b1 : ext;
    sat = int'(mag_full) > MAXV;
    mag = sat ? PW'(MAXV) : PW'(mag_full);
  end
`ifdef CFG_READBACK_EN
  logic [PW-1:0] rb_val;
  always_comb begin
    rb_val = int'(param_sel) < NPARAM ? shadow[param_sel] : '0;
    dout_d = rb_mode ? rb_val : mag;
    sign_d = rb_mode ? 1'b0 : neg;
  end
`else
  logic unused_rb;
  assign unused_rb = rb_mode;
  assign dout_d = mag;
  assign sign_d = neg;
`endif
  always_ff @(posedge clk) begin
    dout <= rst ? '0 : dout_d;
    sign <= rst ? 1'b0 : sign_d;
  end
endmodule
